// File: rtl/regfile_writeback_queue_if.sv
// Bundle of handshake, register-file write-port and forwarding signals for regfile_writeback_queue.
// master = writeback sources / register file side, slave = the queue itself.
interface regfile_writeback_queue_if #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] in_addr;
    logic [DATA_W-1:0] in_data;
    logic              rf_stall;
    logic [ADDR_W-1:0] rf_a3;
    logic              rf_we3;
    logic [DATA_W-1:0] rf_wd3;
    logic [ADDR_W-1:0] fwd_a1;
    logic [ADDR_W-1:0] fwd_a2;
    logic              fwd_hit1;
    logic              fwd_hit2;
    logic [DATA_W-1:0] fwd_data1;
    logic [DATA_W-1:0] fwd_data2;
    logic [CW-1:0]     count;

    modport master (
        output flush, in_valid, in_addr, in_data, rf_stall, fwd_a1, fwd_a2,
        input  in_ready, rf_a3, rf_we3, rf_wd3, fwd_hit1, fwd_hit2, fwd_data1, fwd_data2, count
    );

    modport slave (
        input  flush, in_valid, in_addr, in_data, rf_stall, fwd_a1, fwd_a2,
        output in_ready, rf_a3, rf_we3, rf_wd3, fwd_hit1, fwd_hit2, fwd_data1, fwd_data2, count
    );
endinterface

// File: rtl/regfile_writeback_queue.sv
// In-order writeback FIFO draining one result per cycle onto the register file write port.
// Optional read-port forwarding from queued entries is built when WBQ_FORWARD_EN is defined.
module regfile_writeback_queue #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input logic                     clk,
    input logic                     rst_n,
    regfile_writeback_queue_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [PW-1:0]     head_q;
    logic [PW-1:0]     tail_q;
    logic [CW-1:0]     count_q;

    logic not_empty;
    logic store;
    logic pop;

    assign not_empty = (count_q != '0);
    // Register 0 writes handshake but are never stored; flush drops a same-cycle push.
    assign store     = bus.in_valid && bus.in_ready && (bus.in_addr != '0) && !bus.flush;
    assign pop       = bus.rf_we3;

    assign bus.in_ready = (count_q != CW'(DEPTH));
    assign bus.rf_we3   = not_empty && !bus.rf_stall && !bus.flush;
    assign bus.rf_a3    = not_empty ? addr_q[head_q] : '0;
    assign bus.rf_wd3   = not_empty ? data_q[head_q] : '0;
    assign bus.count    = count_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (bus.flush) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (store) tail_q <= tail_q + PW'(1);
            if (pop)   head_q <= head_q + PW'(1);
            case ({store, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // NOTE: entry storage has no reset; contents are only observed while count marks them occupied.
    always_ff @(posedge clk) begin
        if (store) begin
            addr_q[tail_q] <= bus.in_addr;
            data_q[tail_q] <= bus.in_data;
        end
    end

`ifdef WBQ_FORWARD_EN
    logic [ADDR_W-1:0] fwd_addr [2];
    logic              fwd_hit  [2];
    logic [DATA_W-1:0] fwd_val  [2];

    assign fwd_addr[0] = bus.fwd_a1;
    assign fwd_addr[1] = bus.fwd_a2;

    // Scan oldest to youngest so the youngest match overwrites older ones.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        logic [PW-1:0] idx;
        idx = '0;
        for (int p = 0; p < 2; p++) begin
            fwd_hit[p] = 1'b0;
            fwd_val[p] = '0;
            for (int i = 0; i < DEPTH; i++) begin
                idx = head_q + PW'(i);
                if ((CW'(i) < count_q) && (fwd_addr[p] != '0) && (addr_q[idx] == fwd_addr[p])) begin
                    fwd_hit[p] = 1'b1;
                    fwd_val[p] = data_q[idx];
                end
            end
        end
    end

    assign bus.fwd_hit1  = fwd_hit[0];
    assign bus.fwd_hit2  = fwd_hit[1];
    assign bus.fwd_data1 = fwd_val[0];
    assign bus.fwd_data2 = fwd_val[1];
`else
    assign bus.fwd_hit1  = 1'b0;
    assign bus.fwd_hit2  = 1'b0;
    assign bus.fwd_data1 = '0;
    assign bus.fwd_data2 = '0;
`endif
endmodule

// File: doc/regfile_writeback_queue.md
# regfile_writeback_queue

Write-side companion to the multi-cycle MIPS register file. It buffers completed results (destination register number plus 32-bit value) in a small in-order FIFO and drains them one per cycle onto the register file's single write port (a3/we3/wd3). It sits between the datapath's writeback sources and the register file. Optional forwarding ports let the two register-file read ports see values that are still queued.

## Interface
- DEPTH, 4, number of queue entries; power of two, ≥2
- DATA_W, 32, result width
- ADDR_W, 5, register-number width
- count width CW = $clog2(DEPTH)+1

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset; asynchronous and active-low
- flush  in  1  synchronous discard of all queued entries
- in_valid  in  1  a result is offered
- in_ready  out  1  queue can accept this cycle
- in_addr  in  ADDR_W  destination register
- in_data  in  DATA_W  result value
- rf_stall  in  1  write port is unavailable this cycle
- rf_a3  out  ADDR_W  to register file a3
- rf_we3  out  1  to register file we3
- rf_wd3  out  DATA_W  to register file wd3
- fwd_a1, fwd_a2  in  ADDR_W  read addresses (mirror of a1/a2)
- fwd_hit1, fwd_hit2  out  1  a queued entry matches
- fwd_data1, fwd_data2  out  DATA_W  newest matching queued value
- count  out  CW  occupied entries

## Operation
- Storage: DEPTH entries of {addr, data}, with head/tail pointers that wrap modulo DEPTH and a count register.
- Accept: when in_valid && in_ready at a rising edge.
  - If in_addr != 0, the entry is written at the tail, tail advances, and count increments.
  - If in_addr == 0, the transfer completes but nothing is stored, because register 0 is hardwired to zero.
- in_ready = (count != DEPTH). It ignores a same-cycle pop, so there is no combinational path from rf_stall to in_ready.
- Drain (pop):
  - rf_we3 = (count != 0) && !rf_stall && !flush.
  - rf_a3 and rf_wd3 show the head entry, and are 0 when count == 0.
  - A pop occurs on each edge where rf_we3 = 1. Head advances and count decrements.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- Flush: on the edge with flush = 1, head = tail = 0 and count = 0. It takes priority over push and pop, so a push in the same cycle is dropped. in_ready still reflects the pre-flush count.
- Ordering: writes reach the register file strictly in acceptance order. Two queued writes to the same register therefore resolve to the later value.
- Forwarding (only when compiled in):
  - fwd_hitN = 1 when some occupied entry has addr == fwd_aN and fwd_aN != 0.
  - fwd_dataN = data of the youngest such entry (closest to tail), else 0.
  - Purely combinational over stored entries only. The in_* inputs of the current cycle are not forwarded.

## Timing
- Reset (asynchronous, rst_n low):
  - count = 0, head = tail = 0, entry contents are don't-care.
  - Outputs: in_ready = 1, rf_we3 = 0, rf_a3 = 0, rf_wd3 = 0, fwd_hit* = 0, fwd_data* = 0.
- Reset mid-operation discards all pending writes. No partial write is emitted.
- Latency: an entry accepted at edge N appears on rf_we3/rf_a3/rf_wd3 during cycle N+1 if it is at the head. It is committed to the register file at edge N+1.
- Throughput: one accept and one drain per cycle.
- A stalled head holds rf_a3/rf_wd3 stable. rf_we3 drops only while rf_stall = 1.
- Forwarding outputs change in the same cycle as fwd_a* and the queue state.

## Configuration
- Macro WBQ_FORWARD_EN.
- Defined: match logic for both read ports is built as described above.
- Undefined: no match logic is generated; fwd_hit1/2 and fwd_data1/2 are tied to 0. All other behaviour is identical.

## Test plan
- Reset released, one push of addr 5, data 0xDEADBEEF → next cycle rf_we3 = 1, rf_a3 = 5, rf_wd3 = 0xDEADBEEF. Count goes 1 then 0.
- Hold rf_stall = 1 and push 4 entries (regs 1–4) → count = 4 and in_ready = 0. A fifth push is not accepted. Release the stall → regs 1, 2, 3, 4 drain on four consecutive edges and in_ready returns to 1.
- Push addr 0 with data 0x1234 → transfer handshakes but count stays 0 and rf_we3 never asserts.
- Queue two writes to reg 7 (0x11, then 0x22) with rf_stall held, fwd_a1 = 7, fwd_a2 = 8 → fwd_hit1 = 1, fwd_data1 = 0x22, fwd_hit2 = 0. Without WBQ_FORWARD_EN, all fwd_* = 0.
- With 3 entries queued, assert flush together with in_valid → next cycle count = 0, rf_we3 = 0, and the pushed entry is absent.
- Pull rst_n low asynchronously mid-drain → rf_we3 = 0 and in_ready = 1 immediately. After release, count = 0.
